// File: rtl/ff_bank_arbiter.sv
// Round-robin arbiter that shares one flip-flop register bank between NREQ requesters and sequences its strobes.
// Latency: strobe SETUP_CYC edges after grant, Ack PULSE_CYC edges later, idle one edge after Ack.
// Backpressure: requesters hold Req until Ack; Req is sampled only in IDLE, so later requests wait for the next grant.
module ff_bank_arbiter #(
  parameter int NREQ      = 4,
  parameter int WIDTH     = 4,
  parameter int SETUP_CYC = 2,
  parameter int PULSE_CYC = 1
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic [NREQ-1:0]         Req,
  input  logic [2*NREQ-1:0]       Op,
  input  logic [NREQ*WIDTH-1:0]   Wdata,
  output logic [NREQ-1:0]         Ack,
  output logic                    Busy,
  output logic [$clog2(NREQ)-1:0] Grant_id,
  output logic [WIDTH-1:0]        Bank_D,
  output logic                    Bank_Clk,
  output logic                    Bank_Set,
  output logic                    Bank_Reset,
  output logic [WIDTH-1:0]        Q_shadow
);

  localparam int GW   = $clog2(NREQ);
  localparam int CMAX = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_SET  = 2'b01;
  localparam logic [1:0] OP_CLR  = 2'b10;
  localparam logic [1:0] OP_TOG  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETUP   = 2'd1,
    S_STROBE  = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [GW-1:0]     ptr_q, ptr_d;
  logic [GW-1:0]     gid_q, gid_d;
  logic [1:0]        op_q, op_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic              busy_q, busy_d;
  logic [WIDTH-1:0]  bank_d_q, bank_d_d;
  logic              bank_clk_q, bank_clk_d;
  logic              bank_set_q, bank_set_d;
  logic              bank_rst_q, bank_rst_d;
  logic [WIDTH-1:0]  shadow_q, shadow_d;

  logic              pick_vld;
  logic [GW-1:0]     pick_id;
  logic [GW-1:0]     cand;
  logic [1:0]        pick_op;
  logic [WIDTH-1:0]  pick_wdata;
  logic [WIDTH-1:0]  next_val;

  // Rotating priority search: first requester at or after the pointer, with wrap.
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = '0;
    cand     = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = GW'((int'(ptr_q) + k) % NREQ);
      if (!pick_vld && Req[cand]) begin
        pick_vld = 1'b1;
        pick_id  = cand;
      end
    end
  end

  // Mux the winner's command and data, and compute the value the bank will hold afterwards.
  always_comb begin
    pick_op    = OP_LOAD;
    pick_wdata = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (GW'(k) == pick_id) begin
        pick_op    = Op[2*k +: 2];
        pick_wdata = Wdata[k*WIDTH +: WIDTH];
      end
    end
    case (pick_op)
      OP_LOAD: next_val = pick_wdata;
      OP_SET:  next_val = '1;
      OP_CLR:  next_val = '0;
      OP_TOG:  next_val = ~shadow_q;
      default: next_val = pick_wdata;
    endcase
  end

  // Sequencer next state: grant, setup hold, strobe pulse, release with Ack.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    gid_d      = gid_q;
    op_d       = op_q;
    ack_d      = '0;
    busy_d     = busy_q;
    bank_d_d   = bank_d_q;
    bank_clk_d = bank_clk_q;
    bank_set_d = bank_set_q;
    bank_rst_d = bank_rst_q;
    shadow_d   = shadow_q;
    case (state_q)
      S_IDLE: begin
        bank_clk_d = 1'b0;
        bank_set_d = 1'b0;
        bank_rst_d = 1'b0;
        if (pick_vld) begin
          state_d  = S_SETUP;
          gid_d    = pick_id;
          op_d     = pick_op;
          busy_d   = 1'b1;
          bank_d_d = next_val;
          // The grant edge itself counts as the first setup cycle.
          cnt_d    = CW'(1);
        end
      end
      S_SETUP: begin
        if (cnt_q >= CW'(SETUP_CYC)) begin
          state_d    = S_STROBE;
          cnt_d      = CW'(1);
          bank_clk_d = 1'b1;
          shadow_d   = bank_d_q;
          bank_set_d = (op_q == OP_SET);
          bank_rst_d = (op_q == OP_CLR);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STROBE: begin
        if (cnt_q >= CW'(PULSE_CYC)) begin
          state_d       = S_RELEASE;
          bank_clk_d    = 1'b0;
          bank_set_d    = 1'b0;
          bank_rst_d    = 1'b0;
          ack_d[gid_q]  = 1'b1;
          ptr_d         = (gid_q == GW'(NREQ - 1)) ? '0 : gid_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RELEASE: begin
        // Bank_D stays put this cycle to give the bank its hold time.
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any operation and clears the bank.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      ptr_q      <= '0;
      gid_q      <= '0;
      op_q       <= OP_LOAD;
      ack_q      <= '0;
      busy_q     <= 1'b0;
      bank_d_q   <= '0;
      bank_clk_q <= 1'b0;
      bank_set_q <= 1'b0;
      bank_rst_q <= 1'b1;
      shadow_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      gid_q      <= gid_d;
      op_q       <= op_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
      bank_d_q   <= bank_d_d;
      bank_clk_q <= bank_clk_d;
      bank_set_q <= bank_set_d;
      bank_rst_q <= bank_rst_d;
      shadow_q   <= shadow_d;
    end
  end

  assign Ack        = ack_q;
  assign Busy       = busy_q;
  assign Grant_id   = gid_q;
  assign Bank_D     = bank_d_q;
  assign Bank_Clk   = bank_clk_q;
  assign Bank_Set   = bank_set_q;
  assign Bank_Reset = bank_rst_q;
  assign Q_shadow   = shadow_q;

endmodule

// File: tb/tb_ff_bank_arbiter.sv
// Bench for ff_bank_arbiter with a transaction-level reference model.
// Latency: checks strobe, Ack and idle timing relative to each grant edge.
// Backpressure: requesters hold Req until their Ack, as the bank sharing protocol expects.
module tb_ff_bank_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 4;
  localparam int S    = 2;
  localparam int P    = 1;

  logic                Clk = 1'b0;
  logic                Reset;
  logic [NREQ-1:0]     Req;
  logic [2*NREQ-1:0]   Op;
  logic [NREQ*W-1:0]   Wdata;
  logic [NREQ-1:0]     Ack;
  logic                Busy;
  logic [1:0]          Grant_id;
  logic [W-1:0]        Bank_D;
  logic                Bank_Clk;
  logic                Bank_Set;
  logic                Bank_Reset;
  logic [W-1:0]        Q_shadow;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // reference model state
  int           ptr_m;
  logic [W-1:0] shadow_m;

  // observations gathered by the helpers
  logic [1:0]      gnt_id;
  logic [W-1:0]    d0;
  int              grant_time;
  int              clk_first, clk_cyc, ack_cnt, ack_cyc, busy_cyc;
  logic [NREQ-1:0] ack_val;
  bit              set_seen, rst_seen, both_seen, d_stable, multi_ack;

  ff_bank_arbiter #(
    .NREQ(NREQ), .WIDTH(W), .SETUP_CYC(S), .PULSE_CYC(P)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Req(Req), .Op(Op), .Wdata(Wdata),
    .Ack(Ack), .Busy(Busy), .Grant_id(Grant_id), .Bank_D(Bank_D),
    .Bank_Clk(Bank_Clk), .Bank_Set(Bank_Set), .Bank_Reset(Bank_Reset),
    .Q_shadow(Q_shadow)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // First requester at or after p, wrapping; -1 when nobody asks.
  function automatic int model_pick(logic [NREQ-1:0] r, int p);
    for (int k = 0; k < NREQ; k++)
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  function automatic logic [W-1:0] model_next(logic [1:0] op, logic [W-1:0] wd, logic [W-1:0] sh);
    if (op == 2'b00) return wd;
    if (op == 2'b01) return {W{1'b1}};
    if (op == 2'b10) return {W{1'b0}};
    return ~sh;
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
    cyc++;
  endtask

  // Advance until Busy is seen; records grant observations.
  task automatic wait_grant(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (Busy === 1'b1) begin
        ok         = 1'b1;
        gnt_id     = Grant_id;
        d0         = Bank_D;
        grant_time = cyc;
        return;
      end
    end
  endtask

  // Follow a granted transaction to its end, k0 cycles already elapsed since the grant edge.
  task automatic observe_txn(input int k0, input logic [NREQ-1:0] drop_mask);
    int k;
    clk_first = -1; clk_cyc = 0; ack_cnt = 0; ack_cyc = -1; busy_cyc = -1;
    ack_val = '0; set_seen = 0; rst_seen = 0; both_seen = 0; d_stable = 1; multi_ack = 0;
    k = k0;
    while (k < 40) begin
      tick();
      k++;
      if (Bank_Clk === 1'b1) begin
        if (clk_first < 0) clk_first = k;
        clk_cyc++;
      end
      if (Ack !== '0) begin
        ack_cnt++;
        ack_val = Ack;
        ack_cyc = k;
        if ($countones(Ack) > 1) multi_ack = 1;
        Req = Req & ~drop_mask;
      end
      if (Bank_Set === 1'b1) set_seen = 1;
      if (Bank_Reset === 1'b1) rst_seen = 1;
      if (Bank_Set === 1'b1 && Bank_Reset === 1'b1) both_seen = 1;
      if (Busy === 1'b1) begin
        if (Bank_D !== d0) d_stable = 0;
      end else begin
        busy_cyc = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; Req = '0; Op = '0; Wdata = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({Ack, Busy, Grant_id, Bank_D, Bank_Clk, Bank_Set, Bank_Reset, Q_shadow} !== 18'b0000_0_00_0000_0_0_1_0000) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d: got Ack=%b Busy=%b Gid=%0d D=%h Clk=%b Set=%b Rst=%b Q=%h, want all 0 except Bank_Reset=1",
                 i, Ack, Busy, Grant_id, Bank_D, Bank_Clk, Bank_Set, Bank_Reset, Q_shadow);
      end
    end
    Reset = 1'b0;
    tick();
    checks++;
    if (Bank_Reset !== 1'b0) begin errors++; $display("FAIL reset_release Bank_Reset: got %b want 0", Bank_Reset); end
    checks++;
    if (Q_shadow !== '0 || Busy !== 1'b0) begin errors++; $display("FAIL reset_release state: got Q=%h Busy=%b want 0/0", Q_shadow, Busy); end
    ptr_m = 0; shadow_m = '0;
  endtask

  task automatic test_single_load();
    bit ok;
    logic [NREQ-1:0] ea;
    Req = 4'b0100; Op = '0; Wdata = '0; Wdata[11:8] = 4'hA;
    wait_grant(ok);
    checks++;
    if (!ok || gnt_id !== 2'd2 || d0 !== 4'hA || Bank_Clk !== 1'b0) begin
      errors++; $display("FAIL single_grant: ok=%0d gid=%0d D=%h Clk=%b want 1/2/a/0", ok, gnt_id, d0, Bank_Clk);
    end
    observe_txn(0, 4'b0100);
    ea = 4'b0100;
    checks++;
    if (clk_first !== S || clk_cyc !== P) begin errors++; $display("FAIL single_strobe: first=%0d len=%0d want %0d/%0d", clk_first, clk_cyc, S, P); end
    checks++;
    if (ack_cyc !== S + P || ack_val !== ea || ack_cnt !== 1) begin
      errors++; $display("FAIL single_ack: at %0d val=%b cnt=%0d want %0d/%b/1", ack_cyc, ack_val, ack_cnt, S + P, ea);
    end
    checks++;
    if (busy_cyc !== S + P + 1) begin errors++; $display("FAIL single_idle: busy fell at %0d want %0d", busy_cyc, S + P + 1); end
    checks++;
    if (Q_shadow !== 4'hA || !d_stable) begin errors++; $display("FAIL single_shadow: Q=%h stable=%0d want a/1", Q_shadow, d_stable); end
    shadow_m = 4'hA; ptr_m = 3;
  endtask

  task automatic test_round_robin();
    bit ok;
    int g, prev;
    logic [NREQ-1:0] ea;
    logic [W-1:0] nv;
    Reset = 1'b1; Req = 4'b1111; Op = '0; Wdata = 16'h4321;
    tick(); tick();
    Reset = 1'b0;
    ptr_m = 0; shadow_m = '0; prev = -1;
    for (int i = 0; i < 5; i++) begin
      g = model_pick(Req, ptr_m);
      nv = model_next(Op[2*g +: 2], Wdata[W*g +: W], shadow_m);
      wait_grant(ok);
      checks++;
      if (!ok || gnt_id !== 2'(g) || d0 !== nv) begin
        errors++; $display("FAIL rr_grant %0d: ok=%0d gid=%0d D=%h want %0d/%h", i, ok, gnt_id, d0, g, nv);
      end
      if (prev >= 0) begin
        checks++;
        if (grant_time - prev !== 5) begin errors++; $display("FAIL rr_spacing %0d: got %0d want 5", i, grant_time - prev); end
      end
      prev = grant_time;
      observe_txn(0, (i == 4) ? 4'b1111 : 4'b0000);
      ea = '0; ea[g] = 1'b1;
      checks++;
      if (ack_cnt !== 1 || ack_val !== ea || Q_shadow !== nv) begin
        errors++; $display("FAIL rr_ack %0d: cnt=%0d val=%b Q=%h want 1/%b/%h", i, ack_cnt, ack_val, Q_shadow, ea, nv);
      end
      shadow_m = nv; ptr_m = (g + 1) % NREQ;
    end
  endtask

  task automatic test_commands();
    bit ok;
    int g;
    logic [NREQ-1:0] ea;
    logic [W-1:0] nv;
    int          rq [4] = '{2, 1, 3, 0};
    logic [1:0]  oc [4] = '{2'b00, 2'b11, 2'b01, 2'b10};
    logic [W-1:0] wv [4] = '{4'hA, 4'h3, 4'h6, 4'h9};
    for (int i = 0; i < 4; i++) begin
      Req = '0; Req[rq[i]] = 1'b1;
      Op = '0; Op[2*rq[i] +: 2] = oc[i];
      Wdata = '0; Wdata[W*rq[i] +: W] = wv[i];
      g = model_pick(Req, ptr_m);
      nv = model_next(oc[i], wv[i], shadow_m);
      wait_grant(ok);
      checks++;
      if (!ok || gnt_id !== 2'(g) || d0 !== nv) begin
        errors++; $display("FAIL cmd_grant %0d: ok=%0d gid=%0d D=%h want %0d/%h", i, ok, gnt_id, d0, g, nv);
      end
      observe_txn(0, Req);
      ea = '0; ea[g] = 1'b1;
      checks++;
      if (set_seen !== (oc[i] == 2'b01) || rst_seen !== (oc[i] == 2'b10) || both_seen) begin
        errors++; $display("FAIL cmd_pins %0d: set=%0d rst=%0d both=%0d op=%b", i, set_seen, rst_seen, both_seen, oc[i]);
      end
      checks++;
      if (Q_shadow !== nv || ack_val !== ea || ack_cnt !== 1) begin
        errors++; $display("FAIL cmd_result %0d: Q=%h ack=%b cnt=%0d want %h/%b/1", i, Q_shadow, ack_val, ack_cnt, nv, ea);
      end
      shadow_m = nv; ptr_m = (g + 1) % NREQ;
    end
  endtask

  task automatic test_ignore_changes();
    bit ok;
    Req = 4'b0010; Op = '0; Wdata = '0; Wdata[7:4] = 4'h3;
    wait_grant(ok);
    checks++;
    if (!ok || gnt_id !== 2'd1 || d0 !== 4'h3) begin errors++; $display("FAIL late_grant: ok=%0d gid=%0d D=%h want 1/1/3", ok, gnt_id, d0); end
    tick();
    Op[3:2] = 2'b11; Wdata[7:4] = 4'hC;
    tick();
    checks++;
    if (Bank_Clk !== 1'b1 || Bank_D !== 4'h3 || Q_shadow !== 4'h3) begin
      errors++; $display("FAIL late_strobe: Clk=%b D=%h Q=%h want 1/3/3", Bank_Clk, Bank_D, Q_shadow);
    end
    Req = '0;
    observe_txn(2, '0);
    checks++;
    if (ack_val !== 4'b0010 || ack_cnt !== 1 || ack_cyc !== S + P || Q_shadow !== 4'h3) begin
      errors++; $display("FAIL late_ack: ack=%b cnt=%0d at %0d Q=%h want 0010/1/%0d/3", ack_val, ack_cnt, ack_cyc, S + P, Q_shadow);
    end
    shadow_m = 4'h3; ptr_m = 2; Op = '0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit bad_ack;
    int g;
    Req = 4'b0100; Op = '0; Wdata = '0; Wdata[11:8] = 4'h9;
    wait_grant(ok);
    tick(); tick();
    checks++;
    if (!ok || Bank_Clk !== 1'b1) begin errors++; $display("FAIL abort_pre: ok=%0d Clk=%b want 1/1", ok, Bank_Clk); end
    Reset = 1'b1; Req = '0;
    tick();
    checks++;
    if ({Ack, Busy, Grant_id, Bank_Clk, Bank_Set, Bank_Reset, Q_shadow} !== 14'b0000_0_00_0_0_1_0000) begin
      errors++; $display("FAIL abort_state: Ack=%b Busy=%b Gid=%0d Clk=%b Set=%b Rst=%b Q=%h want 0,0,0,0,0,1,0",
                         Ack, Busy, Grant_id, Bank_Clk, Bank_Set, Bank_Reset, Q_shadow);
    end
    Reset = 1'b0;
    bad_ack = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (Ack !== '0 || Busy !== 1'b0) bad_ack = 1;
    end
    checks++;
    if (bad_ack) begin errors++; $display("FAIL abort_no_ack: got Ack or Busy after abort, want none"); end
    ptr_m = 0; shadow_m = '0;
    Req = 4'b1010; Wdata = 16'h5A5A;
    g = model_pick(Req, ptr_m);
    wait_grant(ok);
    checks++;
    if (!ok || gnt_id !== 2'(g)) begin errors++; $display("FAIL abort_ptr: ok=%0d gid=%0d want %0d", ok, gnt_id, g); end
    observe_txn(0, 4'b1111);
    shadow_m = Wdata[W*g +: W]; ptr_m = (g + 1) % NREQ;
    checks++;
    if (Q_shadow !== shadow_m) begin errors++; $display("FAIL abort_resume: Q=%h want %h", Q_shadow, shadow_m); end
  endtask

  task automatic test_random();
    bit ok;
    int g;
    logic [NREQ-1:0] ea;
    logic [W-1:0] nv;
    logic [1:0] op;
    for (int i = 0; i < 40; i++) begin
      Req   = Req | NREQ'($urandom_range(1, (1 << NREQ) - 1));
      Op    = (2*NREQ)'($urandom);
      Wdata = (NREQ*W)'($urandom);
      g  = model_pick(Req, ptr_m);
      op = Op[2*g +: 2];
      nv = model_next(op, Wdata[W*g +: W], shadow_m);
      wait_grant(ok);
      checks++;
      if (!ok || gnt_id !== 2'(g) || d0 !== nv) begin
        errors++; $display("FAIL rnd_grant %0d: ok=%0d gid=%0d D=%h want %0d/%h", i, ok, gnt_id, d0, g, nv);
      end
      observe_txn(0, NREQ'(1) << g);
      ea = '0; ea[g] = 1'b1;
      checks++;
      if (ack_val !== ea || ack_cnt !== 1 || multi_ack || ack_cyc !== S + P || busy_cyc !== S + P + 1) begin
        errors++; $display("FAIL rnd_ack %0d: ack=%b cnt=%0d at %0d idle %0d want %b/1/%0d/%0d", i, ack_val, ack_cnt, ack_cyc, busy_cyc, ea, S + P, S + P + 1);
      end
      checks++;
      if (Q_shadow !== nv || clk_cyc !== P || !d_stable || both_seen ||
          set_seen !== (op == 2'b01) || rst_seen !== (op == 2'b10)) begin
        errors++; $display("FAIL rnd_bank %0d: Q=%h want %h clk=%0d stable=%0d set=%0d rst=%0d op=%b", i, Q_shadow, nv, clk_cyc, d_stable, set_seen, rst_seen, op);
      end
      shadow_m = nv; ptr_m = (g + 1) % NREQ;
    end
    Req = '0;
  endtask

  initial begin
    Reset = 1'b1; Req = '0; Op = '0; Wdata = '0;
    test_reset();
    test_single_load();
    test_round_robin();
    test_commands();
    test_ignore_changes();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
